twiddle_gen_sdf: RTL and testbench

Parametrised twiddle-factor generator for one stage of the radix-2 SDF pipeline FFT. It replaces per-stage hard-coded cos/sin tables with a single quarter-wave ROM and an internal sample counter. It derives the stage's twiddle index from frame position and supports forward and inverse (conjugate) transforms. It sits beside each butterfly stage and feeds the complex multiplier with a registered, valid-qualified twiddle.

---
 rtl/fft_pkg.sv | 67 ++++++
 rtl/twiddle_qrom.sv | 45 ++++
 rtl/twiddle_gen_sdf.sv | 130 +++++++++++++
 tb/tb_twiddle_gen_sdf.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT datapath.
//   tw_one       : fixed-point value of 1.0 for a BW-bit Q2.(BW-2) twiddle
//   log2_ceil    : clog2 wrapper for counter/index widths
//   idx_width    : width of a quarter-wave ROM index (0..N/4)
//   stage_len    : butterfly block length L of a given stage
//   q_fmt_t      : Q-format description consumed by the complex multiplier
//   qcos         : elaboration-time round(2^frac * cos(2*pi*i/n)), 0 <= i <= n/4
package fft_pkg;

    // 2*pi scaled by 2^30, used by the integer Taylor evaluation in qcos.
    localparam longint TWO_PI_Q30 = 64'sd6746518852;

    typedef struct packed {
        logic [7:0] int_bits;
        logic [7:0] frac_bits;
    } q_fmt_t;

    function automatic int tw_one(input int bw);
        return 1 << (bw - 2);
    endfunction

    function automatic int log2_ceil(input int v);
        return $clog2(v);
    endfunction

    // N/4 < 2^(log2(N)-1), so one bit less than the sample counter suffices.
    function automatic int idx_width(input int n);
        return $clog2(n) - 1;
    endfunction

    function automatic int stage_len(input int n, input int stage);
        return n >> (stage - 1);
    endfunction

    function automatic q_fmt_t tw_qfmt(input int bw);
        q_fmt_t f;
        f.int_bits  = 8'd2;
        f.frac_bits = 8'(bw - 2);
        return f;
    endfunction

    // Integer-only Taylor series in Q30 so the table is a pure constant that
    // every tool folds identically. The first octant uses cos directly; the
    // second octant uses sin of the complement angle to keep |x| <= pi/4,
    // where a dozen terms are far below one LSB of any practical twiddle.
    function automatic longint qcos(input int i, input int n, input int frac);
        longint one_s, x, x2, term, sum;
        int     j;
        bit     use_sin;
        one_s   = 64'sd1 <<< 30;
        use_sin = (8 * i > n);
        j       = use_sin ? (n / 4 - i) : i;
        x       = (TWO_PI_Q30 * longint'(j)) / longint'(n);
        x2      = (x * x) >>> 30;
        term    = use_sin ? x : one_s;
        sum     = term;
        for (int t = 1; t < 12; t++) begin
            if (use_sin)
                term = -((term * x2) >>> 30) / longint'((2 * t) * (2 * t + 1));
            else
                term = -((term * x2) >>> 30) / longint'((2 * t - 1) * (2 * t));
            sum += term;
        end
        return ((sum <<< frac) + (one_s >>> 1)) >>> 30;
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM, C[i] = round(2^(BW_TW-2) * cos(2*pi*i/N)), i = 0..N/4,
// with two independent registered read ports.
//   clk, rst_n         : clock, asynchronous active-low reset
//   cos_idx, sin_idx   : read addresses (always within 0..N/4)
//   cos_val, sin_val   : registered table values (non-negative), one cycle later
module twiddle_qrom
    import fft_pkg::*;
#(
    parameter int    N        = 256,
    parameter int    BW_TW    = 14,
    parameter string ROM_FILE = "tw_qrom.hex"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [idx_width(N)-1:0]  cos_idx,
    input  logic [idx_width(N)-1:0]  sin_idx,
    output logic [BW_TW-1:0]         cos_val,
    output logic [BW_TW-1:0]         sin_val
);

    localparam int DEPTH = N / 4 + 1;

    logic [BW_TW-1:0] tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        assign tbl[i] = BW_TW'(qcos(i, N, BW_TW - 2));
    end

    // ROM_FILE names the hex image the back-end flow writes from this same
    // table; contents are generated here so no external file is needed.
    if (ROM_FILE == "") begin : g_no_image
    end

    // NOTE: the table is constant logic, not storage, so only the read registers take reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_val <= '0;
            sin_val <= '0;
        end else begin
            cos_val <= tbl[cos_idx];
            sin_val <= tbl[sin_idx];
        end
    end

endmodule

// File: rtl/twiddle_gen_sdf.sv
// Twiddle generator for one radix-2 SDF FFT stage. Tracks frame position,
// derives the stage twiddle index, folds it onto a quarter-wave ROM and emits
// a registered, valid-qualified twiddle three clocks after each en.
//   clk, rst_n         : clock, asynchronous active-low reset
//   en                 : sample strobe, one twiddle per en
//   sync               : with en, current sample is frame position 0
//   inv                : with en, 1 = inverse transform (conjugate twiddle)
//   cos_data, sin_data : signed Q2.(BW_TW-2) twiddle (sin_data = -sin forward)
//   tw_valid           : en delayed by three clocks
module twiddle_gen_sdf
    import fft_pkg::*;
#(
    parameter int    N        = 256,
    parameter int    STAGE    = 1,
    parameter int    BW_TW    = 14,
    parameter string ROM_FILE = "tw_qrom.hex"
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync,
    input  logic                    inv,
    output logic signed [BW_TW-1:0] cos_data,
    output logic signed [BW_TW-1:0] sin_data,
    output logic                    tw_valid
);

    localparam int LOG2N = log2_ceil(N);
    localparam int IW    = idx_width(N);
    localparam int L     = stage_len(N, STAGE);
    localparam int SH    = STAGE - 1;

    localparam logic [LOG2N-1:0] L_MASK = LOG2N'(L - 1);
    localparam logic [LOG2N-1:0] L_HALF = LOG2N'(L / 2);
    localparam logic [LOG2N-1:0] QTR    = LOG2N'(N / 4);
    localparam logic [LOG2N-1:0] HALF   = LOG2N'(N / 2);

    logic [LOG2N-1:0] cnt, pos, q, k;
    logic [IW-1:0]    cidx, sidx;
    logic             cneg;

    // P1 registers
    logic             p1_valid, p1_inv, p1_cneg;
    logic [IW-1:0]    p1_cidx, p1_sidx;
    // P2 registers (ROM data lives inside twiddle_qrom)
    logic             p2_valid, p2_inv, p2_cneg;
    logic [BW_TW-1:0] c_val, s_val;

    // Position, stage index and octant fold. The first half of each block
    // uses W^0; the second half steps by 2^(STAGE-1) through the half circle.
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    always_comb begin
        pos = sync ? '0 : cnt;
        q   = pos & L_MASK;
        k   = '0;
        if (q >= L_HALF)
            k = (q - L_HALF) << SH;
        if (k < QTR) begin
            cidx = IW'(k);
            sidx = IW'(QTR - k);
            cneg = 1'b0;
        end else begin
            cidx = IW'(HALF - k);
            sidx = IW'(k - QTR);
            cneg = 1'b1;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so stages update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            p1_valid <= 1'b0;
            p1_inv   <= 1'b0;
            p1_cneg  <= 1'b0;
            p1_cidx  <= '0;
            p1_sidx  <= '0;
        end else begin
            p1_valid <= en;
            p1_inv   <= inv;
            p1_cneg  <= cneg;
            p1_cidx  <= cidx;
            p1_sidx  <= sidx;
            if (en)
                cnt <= pos + LOG2N'(1);
        end
    end

    twiddle_qrom #(
        .N        (N),
        .BW_TW    (BW_TW),
        .ROM_FILE (ROM_FILE)
    ) u_qrom (
        .clk     (clk),
        .rst_n   (rst_n),
        .cos_idx (p1_cidx),
        .sin_idx (p1_sidx),
        .cos_val (c_val),
        .sin_val (s_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2_valid <= 1'b0;
            p2_inv   <= 1'b0;
            p2_cneg  <= 1'b0;
        end else begin
            p2_valid <= p1_valid;
            p2_inv   <= p1_inv;
            p2_cneg  <= p1_cneg;
        end
    end

    // Magnitudes never exceed 2^(BW_TW-2), so negation cannot overflow.
    // Outputs only load on a valid sample and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_data <= '0;
            sin_data <= '0;
            tw_valid <= 1'b0;
        end else begin
            tw_valid <= p2_valid;
            if (p2_valid) begin
                cos_data <= p2_cneg ? -c_val : c_val;
                sin_data <= p2_inv  ?  s_val : -s_val;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_gen_sdf.sv
// Bench for twiddle_gen_sdf: stages 1, 3 and 8 of a 256-point FFT run side by
// side on shared stimulus and are compared with a trigonometric reference.
module tb_twiddle_gen_sdf;

    localparam int N   = 256;
    localparam int BW  = 14;
    localparam int ONE = 4096;

    logic clk = 1'b0;
    logic rst_n, en, sync, inv;
    logic signed [BW-1:0] cos1, sin1, cos3, sin3, cos8, sin8;
    logic v1, v3, v8;

    always #5 clk = ~clk;

    twiddle_gen_sdf #(.N(N), .STAGE(1), .BW_TW(BW), .ROM_FILE("tw_qrom.hex")) u_s1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .inv(inv),
        .cos_data(cos1), .sin_data(sin1), .tw_valid(v1));
    twiddle_gen_sdf #(.N(N), .STAGE(3), .BW_TW(BW), .ROM_FILE("tw_qrom.hex")) u_s3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .inv(inv),
        .cos_data(cos3), .sin_data(sin3), .tw_valid(v3));
    twiddle_gen_sdf #(.N(N), .STAGE(8), .BW_TW(BW), .ROM_FILE("tw_qrom.hex")) u_s8 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .inv(inv),
        .cos_data(cos8), .sin_data(sin8), .tw_valid(v8));

    typedef struct {
        bit valid;
        bit inv;
        int p;
        int c[3];
        int s[3];
    } exp_t;

    exp_t pipe[$];
    int   hold_c[3];
    int   hold_s[3];
    int   pm;
    int   total;
    int   bad;

    function automatic int stage_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 8;
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N); the inverse uses the conjugate.
    task automatic ref_tw(input int p, input int stg, input bit iv, output int c, output int s);
        int  l, q, k, sn;
        real ang;
        l   = N >> (stg - 1);
        q   = p % l;
        k   = (q < l / 2) ? 0 : (q - l / 2) * (1 << (stg - 1));
        ang = 2.0 * 3.14159265358979 * k / N;
        c   = rnd(ONE * $cos(ang));
        sn  = rnd(ONE * $sin(ang));
        s   = iv ? sn : -sn;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] obs_c(input int i);
        return (i == 0) ? cos1 : (i == 1) ? cos3 : cos8;
    endfunction

    function automatic logic signed [31:0] obs_s(input int i);
        return (i == 0) ? sin1 : (i == 1) ? sin3 : sin8;
    endfunction

    function automatic logic obs_v(input int i);
        return (i == 0) ? v1 : (i == 1) ? v3 : v8;
    endfunction

    task automatic reseed();
        exp_t idle;
        idle.valid = 1'b0;
        idle.inv   = 1'b0;
        idle.p     = -1;
        for (int i = 0; i < 3; i++) begin
            idle.c[i] = 0;
            idle.s[i] = 0;
            hold_c[i] = 0;
            hold_s[i] = 0;
        end
        pipe.delete();
        pipe.push_back(idle);
        pipe.push_back(idle);
        pm = 0;
    endtask

    // Hand-worked points of the frame, checked against fixed numbers.
    task automatic spot(input exp_t e);
        int sg;
        if (!e.valid) return;
        sg = e.inv ? 1 : -1;
        chk($sformatf("s8_cos p=%0d", e.p), cos8, ONE);
        chk($sformatf("s8_sin p=%0d", e.p), sin8, 0);
        if (e.p < 128) begin
            chk($sformatf("s1_cos_first_half p=%0d", e.p), cos1, ONE);
            chk($sformatf("s1_sin_first_half p=%0d", e.p), sin1, 0);
        end
        case (e.p)
            160: begin chk("s1_cos p=160", cos1, 2896);  chk("s1_sin p=160", sin1, sg * 2896); end
            192: begin chk("s1_cos p=192", cos1, 0);     chk("s1_sin p=192", sin1, sg * 4096); end
            224: begin chk("s1_cos p=224", cos1, -2896); chk("s1_sin p=224", sin1, sg * 2896); end
            48:  begin chk("s3_cos p=48", cos3, 0);      chk("s3_sin p=48", sin3, sg * 4096);  end
            40:  begin chk("s3_cos p=40", cos3, 2896);   chk("s3_sin p=40", sin3, sg * 2896);  end
            80:  begin chk("s3_cos p=80", cos3, ONE);    chk("s3_sin p=80", sin3, 0);          end
            default: ;
        endcase
    endtask

    // One clock: drive, advance the model, then compare three clocks of history.
    task automatic step(input bit e, input bit sy, input bit iv);
        exp_t n;
        n.valid = e;
        n.inv   = iv;
        n.p     = -1;
        for (int i = 0; i < 3; i++) begin
            n.c[i] = 0;
            n.s[i] = 0;
        end
        if (e) begin
            n.p = sy ? 0 : pm;
            pm  = (n.p + 1) % N;
            for (int i = 0; i < 3; i++)
                ref_tw(n.p, stage_of(i), iv, n.c[i], n.s[i]);
        end
        en   = e;
        sync = sy;
        inv  = iv;
        pipe.push_back(n);
        @(posedge clk);
        #1;
        n = pipe.pop_front();
        if (n.valid) begin
            for (int i = 0; i < 3; i++) begin
                hold_c[i] = n.c[i];
                hold_s[i] = n.s[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid s%0d p=%0d", stage_of(i), n.p), {31'd0, obs_v(i)}, {31'd0, n.valid});
            chk($sformatf("cos s%0d p=%0d", stage_of(i), n.p), obs_c(i), hold_c[i]);
            chk($sformatf("sin s%0d p=%0d", stage_of(i), n.p), obs_s(i), hold_s[i]);
        end
        spot(n);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s valid s%0d", tag, stage_of(i)), {31'd0, obs_v(i)}, 0);
            chk($sformatf("%s cos s%0d", tag, stage_of(i)), obs_c(i), 0);
            chk($sformatf("%s sin s%0d", tag, stage_of(i)), obs_s(i), 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        sync  = 1'b0;
        inv   = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        reseed();
        step(1'b0, 1'b0, 1'b0);

        // Full forward frame starting with sync.
        for (int i = 0; i < N; i++)
            step(1'b1, i == 0, 1'b0);

        // Full frame, inverse only at position 160.
        for (int i = 0; i < N; i++)
            step(1'b1, i == 0, i == 160);

        // Gapped en (1 on, 2 off); sync lands where the count reads 100.
        for (int i = 0; i < 450; i++) begin
            bit e;
            e = (i % 3 == 0);
            step(e, e && (pm == 100), 1'($urandom % 2));
        end

        // Random en density, occasional sync, per-sample inv.
        for (int i = 0; i < 400; i++)
            step(1'($urandom % 4 != 0), 1'($urandom % 50 == 0), 1'($urandom % 2));

        // Mid-frame asynchronous reset just after position 170 is taken.
        step(1'b1, 1'b1, 1'b0);
        while (pm != 171)
            step(1'b1, 1'b0, 1'($urandom % 2));
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        reseed();
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
